morse_tx_encoder: RTL and testbench

- Transmit-side counterpart of the morse keyer/decoder: accepts character codes over a valid/ready handshake and emits timed ITU Morse keying.
- Outputs are a key line (on/off) and a gated square-wave tone for a buzzer/LED pin.
- Sits between a character source (pins or a message ROM) and uo_out/uio_out pins in the top-level wrapper.

---
 rtl/morse_tx_encoder.sv | 208 ++++++++++++++++++++
 tb/tb_morse_tx_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_encoder.sv
// ITU Morse transmitter: accepts A-Z / 0-9 / word-space codes over valid/ready
// and drives a timed key line plus a gated square-wave tone.
module morse_tx_encoder #(
    parameter int UNIT_CYCLES = 2500000,
    parameter int TONE_DIV    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] char_code,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       tone_out,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    // Handshake: a character transfers on a rising edge where char_valid and
    // char_ready are both 1; char_code is sampled only on that edge.
    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    localparam int DW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [CW-1:0] UNIT_M1 = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_M1 = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [DW-1:0] TONE_M1 = DW'(TONE_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MARK     = 3'd1,
        ELEM_GAP = 3'd2,
        CHAR_GAP = 3'd3,
        WORD_GAP = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [2:0]    len_q;
    logic [4:0]    pat_q;
    logic [DW-1:0] div_q;
    logic          key_q;
    logic          tone_q;
    logic          busy_q;

    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;
    logic [7:0]    rom_word;

    // {length, pattern}: pattern is left-aligned, MSB = first element, 1 = dash.
    // A zero length marks codes that are not letters or digits.
    always_comb begin
        rom_word = 8'h00;
        case (char_code)
            6'd0:  rom_word = {3'd2, 5'b01000};
            6'd1:  rom_word = {3'd4, 5'b10000};
            6'd2:  rom_word = {3'd4, 5'b10100};
            6'd3:  rom_word = {3'd3, 5'b10000};
            6'd4:  rom_word = {3'd1, 5'b00000};
            6'd5:  rom_word = {3'd4, 5'b00100};
            6'd6:  rom_word = {3'd3, 5'b11000};
            6'd7:  rom_word = {3'd4, 5'b00000};
            6'd8:  rom_word = {3'd2, 5'b00000};
            6'd9:  rom_word = {3'd4, 5'b01110};
            6'd10: rom_word = {3'd3, 5'b10100};
            6'd11: rom_word = {3'd4, 5'b01000};
            6'd12: rom_word = {3'd2, 5'b11000};
            6'd13: rom_word = {3'd2, 5'b10000};
            6'd14: rom_word = {3'd3, 5'b11100};
            6'd15: rom_word = {3'd4, 5'b01100};
            6'd16: rom_word = {3'd4, 5'b11010};
            6'd17: rom_word = {3'd3, 5'b01000};
            6'd18: rom_word = {3'd3, 5'b00000};
            6'd19: rom_word = {3'd1, 5'b10000};
            6'd20: rom_word = {3'd3, 5'b00100};
            6'd21: rom_word = {3'd4, 5'b00010};
            6'd22: rom_word = {3'd3, 5'b01100};
            6'd23: rom_word = {3'd4, 5'b10010};
            6'd24: rom_word = {3'd4, 5'b10110};
            6'd25: rom_word = {3'd4, 5'b11000};
            6'd26: rom_word = {3'd5, 5'b11111};
            6'd27: rom_word = {3'd5, 5'b01111};
            6'd28: rom_word = {3'd5, 5'b00111};
            6'd29: rom_word = {3'd5, 5'b00011};
            6'd30: rom_word = {3'd5, 5'b00001};
            6'd31: rom_word = {3'd5, 5'b00000};
            6'd32: rom_word = {3'd5, 5'b10000};
            6'd33: rom_word = {3'd5, 5'b11000};
            6'd34: rom_word = {3'd5, 5'b11100};
            6'd35: rom_word = {3'd5, 5'b11110};
            default: rom_word = 8'h00;
        endcase
    end

    assign rom_len = rom_word[7:5];
    assign rom_pat = rom_word[4:0];

    // pat_q is shifted left as elements are consumed, so pat_q[4] is always
    // the element currently (or about to be) keyed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            div_q   <= '0;
            key_q   <= 1'b0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (char_valid) begin
                        if (rom_len != 3'd0) begin
                            state_q <= MARK;
                            cnt_q   <= rom_pat[4] ? DASH_M1 : UNIT_M1;
                            idx_q   <= 3'd0;
                            len_q   <= rom_len;
                            pat_q   <= rom_pat;
                            div_q   <= '0;
                            key_q   <= 1'b1;
                            tone_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (char_code == 6'd36) begin
                            state_q <= WORD_GAP;
                            cnt_q   <= UNIT_M1;
                            idx_q   <= 3'd0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (cnt_q == '0) begin
                        key_q  <= 1'b0;
                        tone_q <= 1'b0;
                        div_q  <= '0;
                        if (idx_q == len_q - 3'd1) begin
                            state_q <= CHAR_GAP;
                            cnt_q   <= DASH_M1;
                        end else begin
                            state_q <= ELEM_GAP;
                            cnt_q   <= UNIT_M1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (div_q == TONE_M1) begin
                            div_q  <= '0;
                            tone_q <= ~tone_q;
                        end else begin
                            div_q <= div_q + DIV_ONE;
                        end
                    end
                end
                ELEM_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= MARK;
                        idx_q   <= idx_q + 3'd1;
                        pat_q   <= pat_q << 1;
                        cnt_q   <= pat_q[3] ? DASH_M1 : UNIT_M1;
                        div_q   <= '0;
                        key_q   <= 1'b1;
                        tone_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                CHAR_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                WORD_GAP: begin
                    // Split into 1 + 3 units so the counter never needs to hold 4 units.
                    if (cnt_q == '0) begin
                        if (idx_q == 3'd0) begin
                            idx_q <= 3'd1;
                            cnt_q <= DASH_M1;
                        end else begin
                            state_q <= IDLE;
                            idx_q   <= 3'd0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    key_q   <= 1'b0;
                    tone_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready  = (state_q == IDLE) & ~rst;
    assign key_out     = key_q;
    assign tone_out    = tone_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Bench for morse_tx_encoder: a per-cycle waveform model built from Morse
// strings, plus directed literal checks on durations and handshake timing.
module tb_morse_tx_encoder;

    localparam int U  = 4;
    localparam int TD = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] char_code = 6'd0;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       key_out;
    logic       tone_out;
    logic       busy;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    morse_tx_encoder #(.UNIT_CYCLES(U), .TONE_DIV(TD)) dut (
        .clk(clk),
        .rst(rst),
        .char_code(char_code),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .key_out(key_out),
        .tone_out(tone_out),
        .busy(busy),
        .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model: per-cycle expected {key, tone, busy} for the cycles ahead
    string morse_tbl [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    logic [2:0] exp_q[$];
    logic [2:0] cur = 3'b000;

    function automatic void push_char(input logic [5:0] code);
        string s;
        int    d;
        int    g;
        if (code == 6'd36) begin
            for (int k = 0; k < 4 * U; k++) exp_q.push_back(3'b001);
        end else if (code < 6'd36) begin
            s = morse_tbl[code];
            for (int i = 0; i < s.len(); i++) begin
                d = (s[i] == "-") ? 3 * U : U;
                for (int k = 0; k < d; k++)
                    exp_q.push_back({1'b1, 1'((k / TD) % 2), 1'b1});
                g = (i == s.len() - 1) ? 3 * U : U;
                for (int k = 0; k < g; k++) exp_q.push_back(3'b001);
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur <= 3'b000;
        end else begin
            if (!cur[0] && char_valid) push_char(char_code);
            if (exp_q.size() != 0) cur <= exp_q.pop_front();
            else cur <= 3'b000;
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // every cycle: {ready, key, tone, busy, state_is_idle} against the model
    task automatic tick();
        logic [4:0] act;
        logic [4:0] exp;
        @(negedge clk);
        act = {char_ready, key_out, tone_out, busy, (dbg_state == 3'd0)};
        exp = {!cur[0] && !rst, cur, !cur[0]};
        check("cycle", 32'(act), 32'(exp));
    endtask

    // driver tasks
    task automatic send(input logic [5:0] code, input bit keep, output int xfer);
        int n = 0;
        char_code  = code;
        char_valid = 1'b1;
        while (!char_ready && n < 1000) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(n >= 1000), 32'd0);
        tick();
        xfer = cyc;
        if (!keep) char_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit scramble, output int nb, output int nk, output int nt);
        int n = 0;
        nb = 0;
        nk = 0;
        nt = 0;
        while (busy && n < 1000) begin
            nb += 32'(busy);
            nk += 32'(key_out);
            nt += 32'(tone_out);
            if (scramble) char_code = 6'($urandom_range(0, 63));
            tick();
            n++;
        end
        check("idle_timeout", 32'(n >= 1000), 32'd0);
        check("ready_after_idle", 32'(char_ready), 32'd1);
    endtask

    int nb, nk, nt;
    int t0, tsp, tt, tinv;
    int lut_code [4] = '{25, 31, 35, 9};
    int lut_busy [4] = '{56, 48, 80, 64};
    int lut_key  [4] = '{32, 20, 52, 40};

    initial begin
        // reset
        tick();
        tick();
        check("rst_outputs", 32'({char_ready, key_out, tone_out, busy}), 32'h0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(char_ready), 32'd1);

        // 'E': one dot then a 3-unit character gap
        send(6'd4, 1'b0, t0);
        check("E_first_key", 32'(key_out), 32'd1);
        wait_idle(1'b0, nb, nk, nt);
        check("E_busy", 32'(nb), 32'd16);
        check("E_key", 32'(nk), 32'd4);
        check("E_tone", 32'(nt), 32'd2);

        // 'A': dot, element gap, dash, character gap
        send(6'd0, 1'b0, t0);
        wait_idle(1'b0, nb, nk, nt);
        check("A_busy", 32'(nb), 32'd32);
        check("A_key", 32'(nk), 32'd16);
        check("A_tone", 32'(nt), 32'd8);

        // '0', word space, 'T' with char_valid held throughout
        send(6'd26, 1'b1, t0);
        send(6'd36, 1'b1, tsp);
        send(6'd19, 1'b0, tt);
        check("zero_to_space", 32'(tsp - t0), 32'd89);
        check("space_to_T", 32'(tt - tsp), 32'd17);
        wait_idle(1'b0, nb, nk, nt);
        check("T_busy", 32'(nb), 32'd24);
        check("T_key", 32'(nk), 32'd12);

        // invalid code is consumed silently; next code goes on the next edge
        send(6'd50, 1'b0, tinv);
        check("invalid_quiet", 32'({busy, char_ready, key_out}), 32'b010);
        send(6'd19, 1'b0, tt);
        check("invalid_then_T", 32'(tt - tinv), 32'd1);
        wait_idle(1'b0, nb, nk, nt);
        check("T2_busy", 32'(nb), 32'd24);

        // more lookup entries with hand-computed durations
        for (int i = 0; i < 4; i++) begin
            send(6'(lut_code[i]), 1'b0, t0);
            wait_idle(1'b0, nb, nk, nt);
            check($sformatf("lut%0d_busy", lut_code[i]), 32'(nb), 32'(lut_busy[i]));
            check($sformatf("lut%0d_key", lut_code[i]), 32'(nk), 32'(lut_key[i]));
        end

        // reset in the middle of the first dash of 'O'
        send(6'd14, 1'b0, t0);
        repeat (4) tick();
        check("O_mid_dash", 32'(key_out), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_outputs", 32'({char_ready, key_out, busy}), 32'b000);
        rst = 1'b0;
        tick();
        check("abort_ready", 32'({char_ready, key_out, busy}), 32'b100);
        send(6'd4, 1'b0, t0);
        wait_idle(1'b0, nb, nk, nt);
        check("E2_busy", 32'(nb), 32'd16);
        check("E2_key", 32'(nk), 32'd4);

        // char_code wiggles while busy must not affect the latched 'A'
        send(6'd0, 1'b0, t0);
        wait_idle(1'b1, nb, nk, nt);
        check("A2_busy", 32'(nb), 32'd32);
        check("A2_key", 32'(nk), 32'd16);
        char_code = 6'd63;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
